// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// k_and_s_pkg / multicycle_control_unit
//
// Multicycle FSM control unit for the K-and-S processor. It sequences
// fetch, decode and execute for the full decoded ISA and drives every
// datapath enable and select. The decoded-instruction type lives in
// k_and_s_pkg, which is placed first in this file.
//
// Parameters:
//   MEM_RD_LAT   cycles an address is held before RAM read data is valid (>=1)
//   MEM_WR_CYC   cycles ram_write_enable is held for a store (>=1)
//   ILLEGAL_HALT 1: unknown decoded_instruction halts; 0: treated as NOP
//
// Optional feature macro: CU_STEP_EN
//   Defined:   adds input 'step'. Each completed instruction parks the FSM
//              in STEP_WAIT (all outputs 0) until a cycle with step=1.
//   Undefined: no 'step' port; instructions chain back-to-back.
//
// Ports:
//   clk                 in   clock, rising edge
//   rst                 in   asynchronous reset, active-high
//   step                in   single-step advance (CU_STEP_EN only)
//   decoded_instruction in   current IR decode
//   zero_op             in   registered zero flag
//   neg_op              in   registered negative flag
//   unsigned_overflow   in   registered unsigned overflow flag (not used by this ISA)
//   signed_overflow     in   registered signed overflow flag (BOV/BNOV)
//   branch              out  PC loads IR address field (with pc_enable)
//   pc_enable           out  PC update
//   ir_enable           out  IR captures RAM data
//   write_reg_enable    out  register-file write
//   addr_sel            out  0: RAM addr = PC, 1: RAM addr = IR address field
//   c_sel               out  0: reg write data = ALU, 1: = RAM
//   operation           out  ALU op: 00 ADD, 01 SUB, 10 AND, 11 OR
//   flags_reg_enable    out  flags register capture
//   ram_write_enable    out  RAM write strobe
//   halt                out  processor halted
//   instr_done          out  pulse in the final cycle of each non-HALT instruction
// ---------------------------------------------------------------------------

package k_and_s_pkg;
    // 5 bits leave room for encodings outside the ISA (illegal opcodes).
    typedef enum logic [4:0] {
        I_NOP    = 5'd0,
        I_LOAD   = 5'd1,
        I_STORE  = 5'd2,
        I_MOVE   = 5'd3,
        I_ADD    = 5'd4,
        I_SUB    = 5'd5,
        I_AND    = 5'd6,
        I_OR     = 5'd7,
        I_BRANCH = 5'd8,
        I_BZERO  = 5'd9,
        I_BNZERO = 5'd10,
        I_BNEG   = 5'd11,
        I_BNNEG  = 5'd12,
        I_BOV    = 5'd13,
        I_BNOV   = 5'd14,
        I_HALT   = 5'd15
    } decoded_instruction_type;
endpackage

module multicycle_control_unit
    import k_and_s_pkg::*;
#(
    parameter int MEM_RD_LAT   = 1,
    parameter int MEM_WR_CYC   = 1,
    parameter int ILLEGAL_HALT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef CU_STEP_EN
    input  logic                    step,
`endif
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    write_reg_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic [1:0]              operation,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
    output logic                    halt,
    output logic                    instr_done
);

    localparam int MAX_WAIT = (MEM_RD_LAT > MEM_WR_CYC) ? MEM_RD_LAT : MEM_WR_CYC;
    localparam int CW       = (MAX_WAIT + 1 > 1) ? $clog2(MAX_WAIT + 1) : 1;

    localparam logic [CW-1:0] RD_LAST = CW'(MEM_RD_LAT - 1);
    localparam logic [CW-1:0] WR_LAST = CW'(MEM_WR_CYC - 1);

    typedef enum logic [3:0] {
        S_FETCH,
        S_IR_LOAD,
        S_DECODE,
        S_MEM_RD,
        S_LOAD_WB,
        S_MEM_WR,
        S_ALU,
        S_MOVE_WB,
        S_BR_TAKE,
`ifdef CU_STEP_EN
        S_STEP_WAIT,
`endif
        S_HALT
    } state_t;

    // Where the FSM goes in the cycle an instruction completes.
`ifdef CU_STEP_EN
    localparam state_t AFTER_DONE = S_STEP_WAIT;
`else
    localparam state_t AFTER_DONE = S_FETCH;
`endif

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] wait_cnt;
    logic          cond_taken;

    // The unsigned overflow flag is part of the flag bus but no opcode tests it.
    logic unused_flags;
    assign unused_flags = unsigned_overflow;

    // Conditional-branch predicate; only consulted while in DECODE.
    always_comb begin
        cond_taken = 1'b0;
        case (decoded_instruction)
            I_BZERO:  cond_taken = zero_op;
            I_BNZERO: cond_taken = ~zero_op;
            I_BNEG:   cond_taken = neg_op;
            I_BNNEG:  cond_taken = ~neg_op;
            I_BOV:    cond_taken = signed_overflow;
            I_BNOV:   cond_taken = ~signed_overflow;
            default:  cond_taken = 1'b0;
        endcase
    end

    // Moore output decode plus next-state selection.
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned; a missing default here would infer a latch.
    always_comb begin
        next_state       = state;
        branch           = 1'b0;
        pc_enable        = 1'b0;
        ir_enable        = 1'b0;
        write_reg_enable = 1'b0;
        addr_sel         = 1'b0;
        c_sel            = 1'b0;
        operation        = 2'b00;
        flags_reg_enable = 1'b0;
        ram_write_enable = 1'b0;
        halt             = 1'b0;
        instr_done       = 1'b0;

        case (state)
            S_FETCH: begin
                if (wait_cnt == RD_LAST) next_state = S_IR_LOAD;
            end
            S_IR_LOAD: begin
                ir_enable  = 1'b1;
                pc_enable  = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                case (decoded_instruction)
                    I_NOP: begin
                        instr_done = 1'b1;
                        next_state = AFTER_DONE;
                    end
                    I_HALT:                    next_state = S_HALT;
                    I_LOAD:                    next_state = S_MEM_RD;
                    I_STORE:                   next_state = S_MEM_WR;
                    I_ADD, I_SUB, I_AND, I_OR: next_state = S_ALU;
                    I_MOVE:                    next_state = S_MOVE_WB;
                    I_BRANCH:                  next_state = S_BR_TAKE;
                    I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV: begin
                        if (cond_taken) begin
                            next_state = S_BR_TAKE;
                        end else begin
                            instr_done = 1'b1;
                            next_state = AFTER_DONE;
                        end
                    end
                    default: begin
                        if (ILLEGAL_HALT != 0) begin
                            next_state = S_HALT;
                        end else begin
                            instr_done = 1'b1;
                            next_state = AFTER_DONE;
                        end
                    end
                endcase
            end
            S_MEM_RD: begin
                addr_sel = 1'b1;
                c_sel    = 1'b1;
                if (wait_cnt == RD_LAST) next_state = S_LOAD_WB;
            end
            S_LOAD_WB: begin
                addr_sel         = 1'b1;
                c_sel            = 1'b1;
                write_reg_enable = 1'b1;
                instr_done       = 1'b1;
                next_state       = AFTER_DONE;
            end
            S_MEM_WR: begin
                addr_sel         = 1'b1;
                ram_write_enable = 1'b1;
                if (wait_cnt == WR_LAST) begin
                    instr_done = 1'b1;
                    next_state = AFTER_DONE;
                end
            end
            S_ALU: begin
                // IR is still held, so the opcode remains valid here.
                case (decoded_instruction)
                    I_SUB:   operation = 2'b01;
                    I_AND:   operation = 2'b10;
                    I_OR:    operation = 2'b11;
                    default: operation = 2'b00;
                endcase
                write_reg_enable = 1'b1;
                flags_reg_enable = 1'b1;
                instr_done       = 1'b1;
                next_state       = AFTER_DONE;
            end
            S_MOVE_WB: begin
                // OR pass-through moves the source operand; flags are left alone.
                operation        = 2'b11;
                write_reg_enable = 1'b1;
                instr_done       = 1'b1;
                next_state       = AFTER_DONE;
            end
            S_BR_TAKE: begin
                branch     = 1'b1;
                pc_enable  = 1'b1;
                instr_done = 1'b1;
                next_state = AFTER_DONE;
            end
`ifdef CU_STEP_EN
            S_STEP_WAIT: begin
                if (step) next_state = S_FETCH;
            end
`endif
            S_HALT: begin
                halt = 1'b1;
            end
            default: next_state = S_FETCH;
        endcase
    end

    // State and wait counter. The counter restarts on every state change and
    // saturates instead of wrapping.
    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            state <= next_state;
            if (next_state != state) begin
                wait_cnt <= '0;
            end else if (wait_cnt != {CW{1'b1}}) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_unit
//
// Two control units with different parameter sets run against a reference
// model that expands each instruction into its expected per-cycle output
// sequence. Unit 0: MEM_RD_LAT=3, MEM_WR_CYC=2, ILLEGAL_HALT=1.
// Unit 1: defaults with ILLEGAL_HALT=0. The unit not under test is held
// in reset. Output vector packing:
//   {branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel,
//    operation[1:0], flags_reg_enable, ram_write_enable, halt, instr_done}
// ---------------------------------------------------------------------------

module tb_multicycle_control_unit;
    import k_and_s_pkg::*;

    localparam int N_HALT = 20;

    localparam logic [11:0] O_BRANCH = 12'h800;
    localparam logic [11:0] O_PC     = 12'h400;
    localparam logic [11:0] O_IR     = 12'h200;
    localparam logic [11:0] O_WRE    = 12'h100;
    localparam logic [11:0] O_ADDR   = 12'h080;
    localparam logic [11:0] O_CSEL   = 12'h040;
    localparam logic [11:0] O_FRE    = 12'h008;
    localparam logic [11:0] O_RWE    = 12'h004;
    localparam logic [11:0] O_HALT   = 12'h002;
    localparam logic [11:0] O_DONE   = 12'h001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst_u    [2];
    decoded_instruction_type dec_u    [2];
    logic [3:0]              flg_u    [2];  // {zero, neg, unsigned_ovf, signed_ovf}
    logic                    branch_u [2];
    logic                    pce_u    [2];
    logic                    ire_u    [2];
    logic                    wre_u    [2];
    logic                    asel_u   [2];
    logic                    csel_u   [2];
    logic [1:0]              op_u     [2];
    logic                    fre_u    [2];
    logic                    rwe_u    [2];
    logic                    halt_u   [2];
    logic                    done_u   [2];
    logic [11:0]             obs      [2];

    int n_tests = 0;
    int n_fail  = 0;
    logic [11:0] exp_q[$];

    multicycle_control_unit #(
        .MEM_RD_LAT(3), .MEM_WR_CYC(2), .ILLEGAL_HALT(1)
    ) dut_a (
        .clk(clk), .rst(rst_u[0]), .decoded_instruction(dec_u[0]),
        .zero_op(flg_u[0][3]), .neg_op(flg_u[0][2]),
        .unsigned_overflow(flg_u[0][1]), .signed_overflow(flg_u[0][0]),
        .branch(branch_u[0]), .pc_enable(pce_u[0]), .ir_enable(ire_u[0]),
        .write_reg_enable(wre_u[0]), .addr_sel(asel_u[0]), .c_sel(csel_u[0]),
        .operation(op_u[0]), .flags_reg_enable(fre_u[0]),
        .ram_write_enable(rwe_u[0]), .halt(halt_u[0]), .instr_done(done_u[0])
    );

    multicycle_control_unit #(
        .MEM_RD_LAT(1), .MEM_WR_CYC(1), .ILLEGAL_HALT(0)
    ) dut_b (
        .clk(clk), .rst(rst_u[1]), .decoded_instruction(dec_u[1]),
        .zero_op(flg_u[1][3]), .neg_op(flg_u[1][2]),
        .unsigned_overflow(flg_u[1][1]), .signed_overflow(flg_u[1][0]),
        .branch(branch_u[1]), .pc_enable(pce_u[1]), .ir_enable(ire_u[1]),
        .write_reg_enable(wre_u[1]), .addr_sel(asel_u[1]), .c_sel(csel_u[1]),
        .operation(op_u[1]), .flags_reg_enable(fre_u[1]),
        .ram_write_enable(rwe_u[1]), .halt(halt_u[1]), .instr_done(done_u[1])
    );

    for (genvar g = 0; g < 2; g++) begin : g_pack
        assign obs[g] = {branch_u[g], pce_u[g], ire_u[g], wre_u[g], asel_u[g],
                         csel_u[g], op_u[g], fre_u[g], rwe_u[g], halt_u[g], done_u[g]};
    end

    function automatic int rd_lat(input int u);
        return (u == 0) ? 3 : 1;
    endfunction

    function automatic int wr_cyc(input int u);
        return (u == 0) ? 2 : 1;
    endfunction

    function automatic bit ill_halts(input int u);
        return (u == 0);
    endfunction

    // Branch predicate from the ISA definition; f = {zero, neg, uovf, sovf}.
    function automatic bit taken(input decoded_instruction_type ins, input logic [3:0] f);
        case (ins)
            I_BZERO:  return f[3] == 1'b1;
            I_BNZERO: return f[3] == 1'b0;
            I_BNEG:   return f[2] == 1'b1;
            I_BNNEG:  return f[2] == 1'b0;
            I_BOV:    return f[0] == 1'b1;
            I_BNOV:   return f[0] == 1'b0;
            default:  return 1'b0;
        endcase
    endfunction

    // Expand one instruction into its expected cycle-by-cycle output words.
    function automatic void build_trace(input int u, input decoded_instruction_type ins,
                                        input logic [3:0] f);
        bit legal;
        exp_q.delete();
        legal = int'(ins) < 16;
        repeat (rd_lat(u)) exp_q.push_back(12'h000);          // fetch
        exp_q.push_back(O_IR | O_PC);                         // IR load
        if (!legal) begin
            if (ill_halts(u)) begin
                exp_q.push_back(12'h000);
                repeat (N_HALT) exp_q.push_back(O_HALT);
            end else begin
                exp_q.push_back(O_DONE);
            end
            return;
        end
        case (ins)
            I_NOP: exp_q.push_back(O_DONE);
            I_HALT: begin
                exp_q.push_back(12'h000);
                repeat (N_HALT) exp_q.push_back(O_HALT);
            end
            I_LOAD: begin
                exp_q.push_back(12'h000);
                repeat (rd_lat(u)) exp_q.push_back(O_ADDR | O_CSEL);
                exp_q.push_back(O_ADDR | O_CSEL | O_WRE | O_DONE);
            end
            I_STORE: begin
                exp_q.push_back(12'h000);
                for (int i = 0; i < wr_cyc(u); i++)
                    exp_q.push_back(O_ADDR | O_RWE | ((i == wr_cyc(u) - 1) ? O_DONE : 12'h000));
            end
            I_ADD: begin exp_q.push_back(12'h000); exp_q.push_back(12'h000 | O_WRE | O_FRE | O_DONE); end
            I_SUB: begin exp_q.push_back(12'h000); exp_q.push_back(12'h010 | O_WRE | O_FRE | O_DONE); end
            I_AND: begin exp_q.push_back(12'h000); exp_q.push_back(12'h020 | O_WRE | O_FRE | O_DONE); end
            I_OR:  begin exp_q.push_back(12'h000); exp_q.push_back(12'h030 | O_WRE | O_FRE | O_DONE); end
            I_MOVE: begin exp_q.push_back(12'h000); exp_q.push_back(12'h030 | O_WRE | O_DONE); end
            I_BRANCH: begin exp_q.push_back(12'h000); exp_q.push_back(O_BRANCH | O_PC | O_DONE); end
            default: begin
                if (taken(ins, f)) begin
                    exp_q.push_back(12'h000);
                    exp_q.push_back(O_BRANCH | O_PC | O_DONE);
                end else begin
                    exp_q.push_back(O_DONE);
                end
            end
        endcase
    endfunction

    // Runs one instruction on unit u, entered just after a falling edge.
    // fsel < 0 picks random decode-cycle flags. Returns right after checking
    // cycle index stop_at (0-based) when stop_at >= 0.
    task automatic run_instr(input int u, input decoded_instruction_type ins, input string name,
                             input int fsel, input int stop_at);
        logic [3:0] f;
        f = (fsel < 0) ? 4'($urandom) : 4'(fsel);
        build_trace(u, ins, f);
        for (int i = 0; i < exp_q.size(); i++) begin
            // Before decode the IR holds stale contents; feed garbage there.
            dec_u[u] = (i <= rd_lat(u)) ? decoded_instruction_type'(5'($urandom)) : ins;
            flg_u[u] = (i == rd_lat(u) + 1) ? f : 4'($urandom);
            #1;
            n_tests++;
            if (obs[u] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s unit%0d cycle%0d: got %03h expected %03h",
                         name, u, i + 1, obs[u], exp_q[i]);
            end
            if (i == stop_at) return;
            @(negedge clk);
        end
    endtask

    task automatic reset_unit(input int u);
        rst_u[1 - u] = 1'b1;
        rst_u[u]     = 1'b1;
        @(negedge clk);
        rst_u[u]     = 1'b0;
    endtask

    task automatic test_reset(input int u);
        rst_u[1 - u] = 1'b1;
        rst_u[u]     = 1'b1;
        for (int c = 0; c < 3; c++) begin
            dec_u[u] = decoded_instruction_type'(5'($urandom));
            flg_u[u] = 4'($urandom);
            #1;
            n_tests++;
            if (obs[u] !== 12'h000) begin
                n_fail++;
                $display("FAIL reset_outputs unit%0d: got %03h expected 000", u, obs[u]);
            end
            @(negedge clk);
        end
        rst_u[u] = 1'b0;
        run_instr(u, I_NOP, "nop_after_reset", -1, -1);
    endtask

    task automatic test_load(input int u);
        reset_unit(u);
        run_instr(u, I_LOAD, "load", -1, -1);
        run_instr(u, I_LOAD, "load_again", -1, -1);
    endtask

    task automatic test_alu(input int u);
        reset_unit(u);
        run_instr(u, I_SUB,  "alu_sub",  -1, -1);
        run_instr(u, I_NOP,  "after_sub", -1, -1);
        run_instr(u, I_ADD,  "alu_add",  -1, -1);
        run_instr(u, I_AND,  "alu_and",  -1, -1);
        run_instr(u, I_OR,   "alu_or",   -1, -1);
        run_instr(u, I_MOVE, "move",     -1, -1);
    endtask

    task automatic test_branch(input int u);
        reset_unit(u);
        run_instr(u, I_BZERO,  "bzero_taken",    4'b1000, -1);
        run_instr(u, I_BZERO,  "bzero_not",      4'b0111, -1);
        run_instr(u, I_BRANCH, "branch",         -1, -1);
        run_instr(u, I_BNEG,   "bneg_taken",     4'b0100, -1);
        run_instr(u, I_BNNEG,  "bnneg_not",      4'b0100, -1);
        run_instr(u, I_BOV,    "bov_uovf_only",  4'b0010, -1);
        run_instr(u, I_BNOV,   "bnov_taken",     4'b0010, -1);
        run_instr(u, I_BNZERO, "bnzero_taken",   4'b0000, -1);
    endtask

    // Reset lands in the final write cycle of a store.
    task automatic test_store_reset(input int u);
        reset_unit(u);
        run_instr(u, I_STORE, "store_full", -1, -1);
        run_instr(u, I_STORE, "store_pre_rst", -1, rd_lat(u) + 1 + wr_cyc(u));
        #2 rst_u[u] = 1'b1;
        #1;
        n_tests++;
        if (obs[u] !== 12'h000) begin
            n_fail++;
            $display("FAIL store_async_rst unit%0d: got %03h expected 000", u, obs[u]);
        end
        @(negedge clk);
        rst_u[u] = 1'b0;
        run_instr(u, I_NOP, "fetch_after_rst", -1, -1);
    endtask

    task automatic test_illegal(input int u);
        decoded_instruction_type ill;
        reset_unit(u);
        ill = decoded_instruction_type'(5'(16 + $urandom_range(0, 15)));
        run_instr(u, ill, "illegal", -1, -1);
        if (!ill_halts(u)) run_instr(u, I_ADD, "after_illegal", -1, -1);
    endtask

    task automatic test_back_to_back(input int u);
        decoded_instruction_type ins;
        reset_unit(u);
        for (int k = 0; k < 30; k++) begin
            if (!ill_halts(u) && ($urandom_range(0, 7) == 0))
                ins = decoded_instruction_type'(5'(16 + $urandom_range(0, 15)));
            else
                ins = decoded_instruction_type'(5'($urandom_range(0, 14)));
            run_instr(u, ins, "b2b", -1, -1);
        end
        run_instr(u, I_HALT, "b2b_halt", -1, -1);
    endtask

    initial begin
        rst_u[0] = 1'b1;
        rst_u[1] = 1'b1;
        dec_u[0] = I_NOP;
        dec_u[1] = I_NOP;
        flg_u[0] = 4'h0;
        flg_u[1] = 4'h0;
        @(negedge clk);
        test_reset(1);
        test_reset(0);
        test_load(0);
        test_load(1);
        test_alu(0);
        test_alu(1);
        test_branch(0);
        test_branch(1);
        test_store_reset(0);
        test_store_reset(1);
        test_illegal(0);
        test_illegal(1);
        test_back_to_back(0);
        test_back_to_back(1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
